mem_port_arbiter: RTL and testbench

- Shares the single synchronous-read data/instruction memory port between two requesters:
  - the CPU controller's memory command stream;
  - a DMA/loader requester.
- Sits between the controller/datapath address mux and the RAM.
- Default: fixed CPU priority. DMA uses free cycles.
- Optional starvation guard forces a DMA slot after a bounded wait.
- Routes each registered read return to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one synchronous-read RAM port between the CPU
// command stream (fixed priority) and a DMA/loader requester.
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int AW         = 9,
   parameter int DW         = 16,
   parameter int STARVE_LIM = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    cpu_m_cmd,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_wait,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_CPU  = 2'b01,
      OWN_DMA  = 2'b10
   } owner_t;

   owner_t rd_owner;
   owner_t rd_owner_nxt;

   logic cpu_req;
   logic force_dma;
   logic cpu_win;
   logic dma_win;

   assign cpu_req = (cpu_m_cmd == CMD_READ) || (cpu_m_cmd == CMD_WRITE);

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [3:0] wait_cnt;

   assign force_dma = (wait_cnt == 4'(STARVE_LIM));

   // Counts only cycles in which DMA is asking and losing; a grant or a
   // withdrawn request restarts the wait, so forced slots never repeat back to back.
   always_ff @(posedge clk) begin
      if (reset || dma_gnt || !dma_req) begin
         wait_cnt <= 4'd0;
      end else if (!force_dma) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end
`else
   logic lim_unused;

   assign force_dma  = 1'b0;
   assign lim_unused = |4'(STARVE_LIM);
`endif

   // Reset suppresses both grants so no RAM access happens while held.
   assign cpu_win = !reset && cpu_req && !(dma_req && force_dma);
   assign dma_win = !reset && dma_req && (!cpu_req || force_dma);

   always_comb begin
      mem_cmd   = CMD_NONE;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (cpu_win) begin
         mem_cmd = cpu_m_cmd;
      end else if (dma_win) begin
         mem_cmd   = {dma_we, ~dma_we};
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end
   end

   assign cpu_wait = cpu_req && !cpu_win && !reset;
   assign dma_gnt  = dma_win;

   always_comb begin
      rd_owner_nxt = OWN_NONE;
      if (cpu_win && (cpu_m_cmd == CMD_READ)) begin
         rd_owner_nxt = OWN_CPU;
      end else if (dma_win && !dma_we) begin
         rd_owner_nxt = OWN_DMA;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_owner <= OWN_NONE;
      end else begin
         rd_owner <= rd_owner_nxt;
      end
   end

   assign dma_rvalid = (rd_owner == OWN_DMA);
   assign dma_rdata  = mem_rdata;
   assign cpu_rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter: self-checking bench with a RAM model and a DMA read
// return scoreboard. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   localparam int AW = 9;
   localparam int DW = 16;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    cpu_m_cmd;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_wait;
   logic [DW-1:0] cpu_rdata;
   logic          dma_req;
   logic          dma_we;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic          dma_gnt;
   logic          dma_rvalid;
   logic [DW-1:0] dma_rdata;
   logic [1:0]    mem_cmd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int errors = 0;
   int rv_seen = 0;
   int rv_exp  = 0;
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] ram [0:(1<<AW)-1];

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(SL)) dut (
      .clk(clk), .reset(reset),
      .cpu_m_cmd(cpu_m_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_wait(cpu_wait), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
      .dma_rdata(dma_rdata),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Synchronous-read RAM: data appears the cycle after the read command.
   always @(posedge clk) begin
      if (mem_cmd == 2'b10) ram[mem_addr] <= mem_wdata;
      if (mem_cmd == 2'b01) mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Every DMA read return is popped and compared against what was pushed at grant time.
   always @(negedge clk) begin
      if (dma_rvalid === 1'b1) begin
         rv_seen++;
         if (sb_q.size() == 0) begin
            chk("rvalid_unexpected", 32'(dma_rvalid), 32'd0);
         end else begin
            chk("dma_rdata", 32'(dma_rdata), 32'(sb_q.pop_front()));
         end
      end
   end

   task automatic drive(input logic rst, input logic [1:0] cmd, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cw, input logic dr, input logic dw,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd);
      @(negedge clk);
      reset = rst; cpu_m_cmd = cmd; cpu_addr = ca; cpu_wdata = cw;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
      #1;
   endtask

   task automatic expect_dma_read(input logic [DW-1:0] d);
      sb_q.push_back(d);
      rv_exp++;
   endtask

   task automatic idle();
      drive(1'b0, 2'b00, 9'h000, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0000);
   endtask

   initial begin
      for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
      ram[5]    = 16'hBEEF;
      mem_rdata = '0;
      reset = 1'b1; cpu_m_cmd = 2'b01; cpu_addr = 9'h003; cpu_wdata = '0;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h005; dma_wdata = '0;

      // Reset held two cycles with both requesting.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 2'b01, 9'h003, 16'h0000, 1'b1, 1'b0, 9'h005, 16'h0000);
         chk("rst_mem_cmd", 32'(mem_cmd), 32'd0);
         chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
         chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
         chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
      end

      // First cycle after release: CPU wins.
      drive(1'b0, 2'b01, 9'h003, 16'h0000, 1'b1, 1'b0, 9'h005, 16'h0000);
      chk("post_rst_mem_cmd", 32'(mem_cmd), 32'd1);
      chk("post_rst_mem_addr", 32'(mem_addr), 32'h003);
      chk("post_rst_cpu_wait", 32'(cpu_wait), 32'd0);
      chk("post_rst_dma_gnt", 32'(dma_gnt), 32'd0);

      // CPU idle, DMA read of 0x05.
      drive(1'b0, 2'b00, 9'h003, 16'h0000, 1'b1, 1'b0, 9'h005, 16'h0000);
      chk("dma_only_gnt", 32'(dma_gnt), 32'd1);
      chk("dma_only_addr", 32'(mem_addr), 32'h005);
      chk("dma_only_cmd", 32'(mem_cmd), 32'd1);
      expect_dma_read(16'hBEEF);
      idle();

      // Contention: CPU write wins, DMA read of the same address follows.
      drive(1'b0, 2'b10, 9'h010, 16'h1234, 1'b1, 1'b0, 9'h010, 16'h0000);
      chk("cont_mem_cmd", 32'(mem_cmd), 32'd2);
      chk("cont_mem_wdata", 32'(mem_wdata), 32'h1234);
      chk("cont_cpu_wait", 32'(cpu_wait), 32'd0);
      chk("cont_dma_gnt", 32'(dma_gnt), 32'd0);
      drive(1'b0, 2'b00, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h010, 16'h0000);
      chk("cont_dma_gnt2", 32'(dma_gnt), 32'd1);
      chk("cont_dma_addr", 32'(mem_addr), 32'h010);
      expect_dma_read(16'h1234);

      // CPU read returns through the passthrough.
      drive(1'b0, 2'b01, 9'h010, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0000);
      idle();
      chk("cpu_rdata", 32'(cpu_rdata), 32'h1234);

      // CPU reads every cycle while DMA keeps requesting.
      for (int i = 1; i <= SL + 4; i++) begin
         drive(1'b0, 2'b01, 9'(i), 16'h0000, 1'b1, 1'b0, 9'h005, 16'h0000);
`ifdef MEM_ARB_STARVE_GUARD_EN
         chk("starve_gnt", 32'(dma_gnt), 32'(i == SL + 1));
         chk("starve_cpu_wait", 32'(cpu_wait), 32'(i == SL + 1));
         if (i == SL + 1) begin
            chk("starve_addr", 32'(mem_addr), 32'h005);
            expect_dma_read(16'hBEEF);
            break;
         end
`else
         chk("strict_gnt", 32'(dma_gnt), 32'd0);
         chk("strict_cpu_wait", 32'(cpu_wait), 32'd0);
`endif
      end
      idle();

      // DMA read granted, then reset on the next cycle: that return is the
      // last one; reset clears the owner so nothing follows.
      drive(1'b0, 2'b00, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h005, 16'h0000);
      chk("prerst_gnt", 32'(dma_gnt), 32'd1);
      expect_dma_read(16'hBEEF);
      drive(1'b1, 2'b00, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h005, 16'h0000);
      chk("midrst_gnt", 32'(dma_gnt), 32'd0);
      chk("midrst_mem_cmd", 32'(mem_cmd), 32'd0);
      idle();
      chk("midrst_rvalid", 32'(dma_rvalid), 32'd0);

      // Command 11 is no request: DMA write goes through, then read it back.
      drive(1'b0, 2'b11, 9'h033, 16'h5555, 1'b1, 1'b1, 9'h030, 16'hA5A5);
      chk("cmd11_gnt", 32'(dma_gnt), 32'd1);
      chk("cmd11_mem_cmd", 32'(mem_cmd), 32'd2);
      chk("cmd11_cpu_wait", 32'(cpu_wait), 32'd0);
      chk("cmd11_addr", 32'(mem_addr), 32'h030);
      chk("cmd11_wdata", 32'(mem_wdata), 32'hA5A5);
      drive(1'b0, 2'b00, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h030, 16'h0000);
      chk("rdback_gnt", 32'(dma_gnt), 32'd1);
      expect_dma_read(16'hA5A5);
      // Back-to-back: CPU write right after the DMA grant, no gap.
      drive(1'b0, 2'b10, 9'h040, 16'h7777, 1'b0, 1'b0, 9'h000, 16'h0000);
      chk("b2b_mem_cmd", 32'(mem_cmd), 32'd2);
      idle();
      idle();

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      chk("rvalid_count", 32'(rv_seen), 32'(rv_exp));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
